// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM states, access sizes and pipeline payloads.
// MEM_MISALIGN_CHECK_EN adds the alignment helper used by the optional misalign trap.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAITING,
    OVER
  } mem_access_state_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic   mem_access;
    logic   mem_write;
    logic   mem_unsigned;
    msize_t msize;
    logic   reg_write;
    logic   misalign;
  } control_t;

  typedef struct packed {
    control_t    ctl;
    logic [63:0] rd;
    logic [63:0] aluout;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [4:0]  dst;
    logic [31:0] instr;
  } exec_data_t;

  typedef struct packed {
    control_t    ctl;
    logic [63:0] writedata;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata;
    logic [4:0]  dst;
    logic [31:0] instr;
  } mem_data_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dst;
    logic [63:0] data;
  } fwd_data_t;

`ifdef MEM_MISALIGN_CHECK_EN
  // An access is aligned when the lane offset is a multiple of its size.
  function automatic logic is_misaligned(msize_t size, logic [2:0] lane);
    case (size)
      MSIZE1:  return 1'b0;
      MSIZE2:  return lane[0];
      MSIZE4:  return |lane[1:0];
      default: return |lane;
    endcase
  endfunction
`endif

endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane logic: bus size code, store strobe/data placement and
// load data extraction with sign or zero extension.
module mem_align
  import mem_stage_pkg::*;
(
  input  msize_t      i_msize,
  input  logic        i_unsigned,
  input  logic [2:0]  i_lane,
  input  logic [63:0] i_store_data,
  input  logic [63:0] i_resp_data,
  output logic [2:0]  o_size,
  output logic [7:0]  o_strobe,
  output logic [63:0] o_store_data,
  output logic [63:0] o_load_data
);

  logic [5:0]  w_bit_shift;
  logic [7:0]  w_base_strobe;
  logic [63:0] w_resp_shifted;
  logic        w_sign;

  assign w_bit_shift    = {i_lane, 3'b000};
  assign o_size         = {1'b0, i_msize};
  assign w_resp_shifted = i_resp_data >> w_bit_shift;
  assign o_store_data   = i_store_data << w_bit_shift;
  assign o_strobe       = w_base_strobe << i_lane;

  always_comb begin
    w_base_strobe = 8'hFF;
    w_sign        = 1'b0;
    o_load_data   = w_resp_shifted;
    case (i_msize)
      MSIZE1: begin
        w_base_strobe = 8'h01;
        w_sign        = ~i_unsigned & w_resp_shifted[7];
        o_load_data   = {{56{w_sign}}, w_resp_shifted[7:0]};
      end
      MSIZE2: begin
        w_base_strobe = 8'h03;
        w_sign        = ~i_unsigned & w_resp_shifted[15];
        o_load_data   = {{48{w_sign}}, w_resp_shifted[15:0]};
      end
      MSIZE4: begin
        w_base_strobe = 8'h0F;
        w_sign        = ~i_unsigned & w_resp_shifted[31];
        o_load_data   = {{32{w_sign}}, w_resp_shifted[31:0]};
      end
      default: begin
        w_base_strobe = 8'hFF;
        o_load_data   = w_resp_shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-bus requests, waits for the response and
// registers the result for writeback. MEM_MISALIGN_CHECK_EN enables the misalign trap.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  input  exec_data_t  i_in_data,
  input  logic        i_flush,
  output logic        o_dreq_valid,
  output logic [63:0] o_dreq_addr,
  output logic [2:0]  o_dreq_size,
  output logic [7:0]  o_dreq_strobe,
  output logic [63:0] o_dreq_data,
  input  logic        i_dresp_data_ok,
  input  logic [63:0] i_dresp_data,
  output logic        o_out_valid,
  output mem_data_t   o_out_data,
  output logic        o_stall,
  output fwd_data_t   o_fwd
);

  mem_access_state_t r_state;
  exec_data_t        r_pend;
  logic              r_flushed;
  logic              r_out_valid;
  mem_data_t         r_out_data;

  exec_data_t  w_src;
  logic        w_misalign;
  logic        w_req_new;
  logic        w_alu_new;
  logic        w_dreq_valid;
  logic [2:0]  w_size;
  logic [7:0]  w_strobe;
  logic [63:0] w_store_data;
  logic [63:0] w_load_data;
  mem_data_t   w_result;

  // While waiting, the request is rebuilt from the latched instruction so it stays stable.
  assign w_src = (r_state == IDLE) ? i_in_data : r_pend;

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = i_in_data.ctl.mem_access &
                      is_misaligned(i_in_data.ctl.msize, i_in_data.aluout[2:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_new = i_rst_n && (r_state == IDLE) && i_in_valid && !i_flush &&
                     i_in_data.ctl.mem_access && !w_misalign;
  assign w_alu_new = i_in_valid && !i_flush && !i_in_data.ctl.mem_access;

  assign w_dreq_valid  = w_req_new || (r_state == WAITING);
  assign o_dreq_valid  = w_dreq_valid;
  assign o_stall       = w_dreq_valid;
  assign o_dreq_addr   = w_dreq_valid ? w_src.aluout : '0;
  assign o_dreq_size   = w_dreq_valid ? w_size : '0;
  assign o_dreq_strobe = (w_dreq_valid && w_src.ctl.mem_write) ? w_strobe : '0;
  assign o_dreq_data   = (w_dreq_valid && w_src.ctl.mem_write) ? w_store_data : '0;

  mem_align u_align (
    .i_msize      (w_src.ctl.msize),
    .i_unsigned   (w_src.ctl.mem_unsigned),
    .i_lane       (w_src.aluout[2:0]),
    .i_store_data (w_src.rd),
    .i_resp_data  (i_dresp_data),
    .o_size       (w_size),
    .o_strobe     (w_strobe),
    .o_store_data (w_store_data),
    .o_load_data  (w_load_data)
  );

  always_comb begin
    w_result           = '0;
    w_result.ctl       = w_src.ctl;
    w_result.csr_we    = w_src.csr_we;
    w_result.csr_addr  = w_src.csr_addr;
    w_result.csr_wdata = w_src.csr_wdata;
    w_result.dst       = w_src.dst;
    w_result.instr     = w_src.instr;
    if (!w_src.ctl.mem_access) begin
      w_result.writedata = w_src.aluout;
    end else if (!w_src.ctl.mem_write) begin
      w_result.writedata = w_load_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_flushed   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_flushed   <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
          if (w_req_new) begin
            r_pend <= i_in_data;
            if (i_dresp_data_ok) begin
              r_state     <= OVER;
              r_out_valid <= 1'b1;
              r_out_data  <= w_result;
            end else begin
              r_state <= WAITING;
            end
          end else if (w_alu_new) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
          end
`ifdef MEM_MISALIGN_CHECK_EN
          else if (i_in_valid && !i_flush && w_misalign) begin
            r_out_valid            <= 1'b1;
            r_out_data             <= w_result;
            r_out_data.writedata   <= '0;
            r_out_data.ctl.misalign <= 1'b1;
          end
`endif
        end
        WAITING: begin
          // A flush seen at any point of the wait still lets the bus finish, but drops the result.
          if (i_flush) begin
            r_flushed <= 1'b1;
          end
          if (i_dresp_data_ok) begin
            r_state <= OVER;
            if (!(r_flushed || i_flush)) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_result;
            end
          end
        end
        OVER: begin
          r_state     <= IDLE;
          r_flushed   <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_data  <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_fwd.valid = r_out_valid & r_out_data.ctl.reg_write;
  assign o_fwd.dst   = r_out_data.dst;
  assign o_fwd.data  = r_out_data.writedata;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with randomized loads/stores/ALU traffic
// against a byte-lane reference model; MEM_MISALIGN_CHECK_EN adds the misalign scenario.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  exec_data_t  in_data;
  logic        flush;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        data_ok;
  logic [63:0] resp_data;
  logic        out_valid;
  mem_data_t   out_data;
  logic        stall;
  fwd_data_t   fwd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_in_valid      (in_valid),
    .i_in_data       (in_data),
    .i_flush         (flush),
    .o_dreq_valid    (dreq_valid),
    .o_dreq_addr     (dreq_addr),
    .o_dreq_size     (dreq_size),
    .o_dreq_strobe   (dreq_strobe),
    .o_dreq_data     (dreq_data),
    .i_dresp_data_ok (data_ok),
    .i_dresp_data    (resp_data),
    .o_out_valid     (out_valid),
    .o_out_data      (out_data),
    .o_stall         (stall),
    .o_fwd           (fwd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exec_data_t mk(bit mem, bit wr, bit uns, int bytes,
                                    logic [63:0] addr, logic [63:0] rd, bit rw);
    exec_data_t e;
    e = '0;
    e.ctl.mem_access   = mem;
    e.ctl.mem_write    = wr;
    e.ctl.mem_unsigned = uns;
    e.ctl.msize        = msize_t'(2'($clog2(bytes)));
    e.ctl.reg_write    = rw;
    e.rd               = rd;
    e.aluout           = addr;
    e.csr_addr         = 12'($urandom);
    e.dst              = 5'($urandom);
    e.instr            = $urandom;
    return e;
  endfunction

  // Reference load: pick the addressed bytes, then sign- or zero-extend.
  function automatic logic [63:0] model_load(int bytes, bit uns, int lane, logic [63:0] resp);
    logic [63:0] v, mask;
    v = resp >> (8 * lane);
    if (bytes == 8) return v;
    mask = (64'd1 << (8 * bytes)) - 64'd1;
    v = v & mask;
    if (!uns && v[8*bytes-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_mem(string tag, bit wr, bit uns, int bytes, logic [63:0] addr,
                        logic [63:0] rd, logic [63:0] resp, int delay);
    exec_data_t  e;
    int          lane, s;
    logic [63:0] exp_wd, exp_sd;
    logic [7:0]  exp_strb;
    lane     = int'(addr[2:0]);
    e        = mk(1'b1, wr, uns, bytes, addr, rd, !wr);
    exp_wd   = wr ? 64'd0 : model_load(bytes, uns, lane, resp);
    s        = ((1 << bytes) - 1) << lane;
    exp_strb = wr ? s[7:0] : 8'h00;
    exp_sd   = wr ? (rd << (8 * lane)) : 64'd0;
    in_valid  = 1'b1;
    in_data   = e;
    resp_data = resp;
    for (int c = 0; c <= delay; c++) begin
      data_ok = (c == delay);
      #1;
      tests++;
      if (dreq_valid !== 1'b1 || stall !== 1'b1) begin
        fails++;
        $display("[TB] FAIL %s req_stall: got valid=%b stall=%b expected 1/1", tag, dreq_valid, stall);
      end
      tests++;
      if (dreq_addr !== addr || dreq_size !== 3'($clog2(bytes))) begin
        fails++;
        $display("[TB] FAIL %s addr_size: got %h/%0d expected %h/%0d", tag, dreq_addr, dreq_size, addr, $clog2(bytes));
      end
      tests++;
      if (dreq_strobe !== exp_strb || dreq_data !== exp_sd) begin
        fails++;
        $display("[TB] FAIL %s strobe_data: got %h/%h expected %h/%h", tag, dreq_strobe, dreq_data, exp_strb, exp_sd);
      end
      tick();
    end
    data_ok  = 1'b0;
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_data.writedata !== exp_wd || out_data.dst !== e.dst) begin
      fails++;
      $display("[TB] FAIL %s result: got v=%b wd=%h dst=%0d expected v=1 wd=%h dst=%0d", tag, out_valid, out_data.writedata, out_data.dst, exp_wd, e.dst);
    end
    tests++;
    if (fwd.valid !== (wr ? 1'b0 : 1'b1) || stall !== 1'b0 || dreq_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s over: got fwd=%b stall=%b dreq=%b expected fwd=%b stall=0 dreq=0", tag, fwd.valid, stall, dreq_valid, !wr);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s pulse: got out_valid=%b expected 0", tag, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    flush    = 1'b0;
    data_ok  = 1'b0;
    resp_data = '0;
    in_valid = 1'b1;
    in_data  = mk(1'b1, 1'b1, 1'b0, 8, 64'h2000, 64'h1234, 1'b0);
    #3;
    tests++;
    if (dreq_valid !== 1'b0 || dreq_strobe !== 8'h00 || stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_bus: got dreq=%b strobe=%h stall=%b expected 0/00/0", dreq_valid, dreq_strobe, stall);
    end
    tick();
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || fwd !== '0) begin
      fails++;
      $display("[TB] FAIL reset_out: got v=%b data=%h fwd=%h expected all zero", out_valid, out_data, fwd);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
  endtask

  task automatic test_alu_back_to_back();
    exec_data_t e, prev;
    bit v, prev_v;
    prev   = '0;
    prev_v = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      v = (i < 16) && ($urandom_range(0, 3) != 0);
      e = mk(1'b0, 1'b0, 1'b0, 8, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      in_valid = v;
      in_data  = e;
      #1;
      if (i > 0) begin
        tests++;
        if (out_valid !== prev_v || out_data.writedata !== (prev_v ? prev.aluout : 64'd0) || stall !== 1'b0) begin
          fails++;
          $display("[TB] FAIL alu_out[%0d]: got v=%b wd=%h stall=%b expected v=%b wd=%h stall=0", i, out_valid, out_data.writedata, stall, prev_v, prev_v ? prev.aluout : 64'd0);
        end
        tests++;
        if (fwd.valid !== (prev_v & prev.ctl.reg_write) || fwd.dst !== (prev_v ? prev.dst : 5'd0)) begin
          fails++;
          $display("[TB] FAIL alu_fwd[%0d]: got v=%b dst=%0d expected v=%b dst=%0d", i, fwd.valid, fwd.dst, prev_v & prev.ctl.reg_write, prev_v ? prev.dst : 5'd0);
        end
      end
      prev   = e;
      prev_v = v;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush_idle();
    in_valid = 1'b1;
    in_data  = mk(1'b0, 1'b0, 1'b0, 8, 64'hDEAD, 64'd0, 1'b1);
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || fwd.valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_idle: got v=%b data=%h fwd=%b expected 0/0/0", out_valid, out_data, fwd.valid);
    end
    tick();
  endtask

  task automatic test_load();
    int bytes, lane, d;
    bit uns;
    logic [63:0] addr;
    do_mem("lb_lane3", 1'b0, 1'b0, 1, 64'h0000_0000_0000_1003, 64'd0, 64'h0000_0000_8000_0000, 1);
    for (int i = 0; i < 12; i++) begin
      bytes = 1 << $urandom_range(0, 3);
      uns   = (bytes == 8) ? 1'b0 : 1'($urandom_range(0, 1));
      lane  = $urandom_range(0, 7) & ~(bytes - 1);
      addr  = ({$urandom, $urandom} & ~64'h7) | 64'(lane);
      d     = $urandom_range(0, 3);
      do_mem("load_rand", 1'b0, uns, bytes, addr, 64'd0, {$urandom, $urandom}, d);
    end
  endtask

  task automatic test_store();
    int bytes, lane;
    logic [63:0] addr;
    do_mem("sh_fixed", 1'b1, 1'b0, 2, 64'h1006, 64'hBEEF, 64'd0, 0);
    for (int i = 0; i < 8; i++) begin
      bytes = 1 << $urandom_range(0, 3);
      lane  = $urandom_range(0, 7) & ~(bytes - 1);
      addr  = ({$urandom, $urandom} & ~64'h7) | 64'(lane);
      do_mem("store_rand", 1'b1, 1'b0, bytes, addr, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2));
    end
  endtask

  task automatic test_ld_delay();
    logic [63:0] resp, a0;
    int stall_cnt, ov_cnt;
    bit stable, data_good;
    resp      = {$urandom, $urandom};
    in_data   = mk(1'b1, 1'b0, 1'b0, 8, 64'h0000_0000_0000_4A08, 64'd0, 1'b1);
    resp_data = resp;
    stall_cnt = 0;
    ov_cnt    = 0;
    stable    = 1'b1;
    data_good = 1'b1;
    a0        = 64'h4A08;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c <= 6);
      data_ok  = (c == 5);
      #1;
      if (stall === 1'b1) stall_cnt++;
      if (dreq_valid === 1'b1 && (dreq_addr !== a0 || dreq_size !== 3'd3 || dreq_strobe !== 8'h00)) stable = 1'b0;
      if (out_valid === 1'b1) begin
        ov_cnt++;
        if (out_data.writedata !== resp) data_good = 1'b0;
      end
      tick();
    end
    data_ok  = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (stall_cnt != 6) begin
      fails++;
      $display("[TB] FAIL ld_delay_stall: got %0d cycles expected 6", stall_cnt);
    end
    tests++;
    if (!stable) begin
      fails++;
      $display("[TB] FAIL ld_delay_stable: got unstable request expected stable addr %h", a0);
    end
    tests++;
    if (ov_cnt != 1 || !data_good) begin
      fails++;
      $display("[TB] FAIL ld_delay_out: got %0d pulses data_ok=%b expected 1 pulse with %h", ov_cnt, data_good, resp);
    end
  endtask

  task automatic test_flush_waiting();
    bit held, ov_seen, fwd_seen, after;
    in_data   = mk(1'b1, 1'b0, 1'b0, 8, 64'h8000, 64'd0, 1'b1);
    resp_data = {$urandom, $urandom};
    held      = 1'b1;
    ov_seen   = 1'b0;
    fwd_seen  = 1'b0;
    after     = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 2);
      flush    = (c == 2);
      data_ok  = (c == 4);
      #1;
      if (c <= 4 && dreq_valid !== 1'b1) held = 1'b0;
      if (c > 4 && dreq_valid === 1'b1) after = 1'b1;
      if (out_valid === 1'b1) ov_seen = 1'b1;
      if (fwd.valid === 1'b1) fwd_seen = 1'b1;
      tick();
    end
    flush   = 1'b0;
    data_ok = 1'b0;
    tests++;
    if (!held || after) begin
      fails++;
      $display("[TB] FAIL flush_wait_dreq: got held=%b later=%b expected held=1 later=0", held, after);
    end
    tests++;
    if (ov_seen || fwd_seen) begin
      fails++;
      $display("[TB] FAIL flush_wait_out: got out_valid=%b fwd=%b expected 0/0", ov_seen, fwd_seen);
    end
  endtask

  task automatic test_reset_waiting();
    bit ov_seen;
    in_valid = 1'b1;
    in_data  = mk(1'b1, 1'b0, 1'b0, 8, 64'h9000, 64'd0, 1'b1);
    data_ok  = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (dreq_valid !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_wait_async: got dreq=%b stall=%b expected 0/0", dreq_valid, stall);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    tests++;
    if (dreq_valid !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_wait_idle: got dreq=%b stall=%b expected 0/0", dreq_valid, stall);
    end
    data_ok   = 1'b1;
    resp_data = {$urandom, $urandom};
    tick();
    data_ok = 1'b0;
    ov_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (out_valid === 1'b1) ov_seen = 1'b1;
      tick();
    end
    tests++;
    if (ov_seen) begin
      fails++;
      $display("[TB] FAIL rst_wait_stray: got out_valid=1 expected 0");
    end
  endtask

`ifdef MEM_MISALIGN_CHECK_EN
  task automatic test_misalign();
    in_valid = 1'b1;
    in_data  = mk(1'b1, 1'b0, 1'b0, 4, 64'h1002, 64'd0, 1'b1);
    #1;
    tests++;
    if (dreq_valid !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("[TB] FAIL misalign_req: got dreq=%b stall=%b expected 0/0", dreq_valid, stall);
    end
    tick();
    in_valid = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_data.writedata !== 64'd0 || out_data.ctl.misalign !== 1'b1 || dreq_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL misalign_out: got v=%b wd=%h mis=%b dreq=%b expected 1/0/1/0", out_valid, out_data.writedata, out_data.ctl.misalign, dreq_valid);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_flush_idle();
    test_load();
    test_store();
    test_ld_delay();
    test_flush_waiting();
    test_reset_waiting();
`ifdef MEM_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
